matrix_seq_ctrl: RTL

- Sequencer for the fixed-point matrix-vector product: one shared multiply-accumulate lane, N*N products time-multiplexed instead of N*N parallel multipliers.
- Latches input vector A on a start handshake and streams matrix B from an external single-port weight memory, one element per cycle.
- Emits one saturated 16-bit result per row over a valid/ready output port.
- Sits between the host/command logic and the weight RAM.

---
 rtl/matrix_pkg.sv | 17 +
 rtl/mac_q_sat.sv | 42 ++++
 rtl/matrix_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix-vector sequencer and its MAC lane.
package matrix_pkg;

  localparam int unsigned N     = 64;
  localparam int unsigned W     = 16;
  localparam int unsigned ACC_W = W + $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} stateT;

  // Clamp an unsigned accumulator to its low w bits, all ones on overflow.
  function automatic logic [63:0] satNarrow(input logic [63:0] acc, input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((acc & ~mask) != 64'd0) ? mask : (acc & mask);
  endfunction

endpackage

// File: rtl/mac_q_sat.sv
// Fixed-point multiply-accumulate lane: upper-half product term, clear/hold, saturated view.
module mac_q_sat #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 22
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sat_c
);

  logic [2*W-1:0]   prod;
  logic [W-1:0]     term;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;

  always_comb begin
    prod    = (2*W)'(a) * (2*W)'(b);
    term    = prod[2*W-1:W];
    accNext = acc;
    if (clear) begin
      accNext = '0;
    end else if (en) begin
      accNext = acc + ACC_W'(term);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      acc <= accNext;
    end
  end

  // Saturated value of what acc holds after this edge, so a caller can register it in step.
  assign sat_c = W'(matrix_pkg::satNarrow(64'(accNext), W));

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Time-multiplexed matrix-vector product sequencer: streams B row-major through one MAC lane.
module matrix_seq_ctrl #(
  parameter int unsigned N  = matrix_pkg::N,
  parameter int unsigned W  = matrix_pkg::W,
  parameter int unsigned AW = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N*W-1:0]       vec_a,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd,
  output logic [AW-1:0]        mem_addr,
  input  logic [W-1:0]         mem_rdata,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_idx,
  output logic [W-1:0]         res_data
);

  import matrix_pkg::stateT;
  import matrix_pkg::IDLE;
  import matrix_pkg::RUN;
  import matrix_pkg::DRAIN;
  import matrix_pkg::OUT;

  localparam int unsigned LOGN  = $clog2(N);
  localparam int unsigned ACC_W = W + LOGN;

  stateT            state, stateNext;
  logic [LOGN-1:0]  row, rowNext;
  logic [LOGN-1:0]  col, colNext;
  logic [LOGN-1:0]  colD;
  logic [N*W-1:0]   vecA, vecANext;
  logic             rdValid;
  logic             accClear;
  logic [W-1:0]     aSel;
  logic [W-1:0]     sat_c;

  logic             busyNext, doneNext, memRdNext, resValidNext;
  logic [AW-1:0]    memAddrNext;
  logic [LOGN-1:0]  resIdxNext;
  logic [W-1:0]     resDataNext;

  // Read data lands one cycle after the strobe; colD pairs it with its vector element.
  assign aSel = vecA[colD*W +: W];

  mac_q_sat #(.W(W), .ACC_W(ACC_W)) macLane (
    .clock (clock),
    .reset (reset),
    .clear (accClear),
    .en    (rdValid),
    .a     (aSel),
    .b     (mem_rdata),
    .sat_c (sat_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      colD      <= '0;
      vecA      <= '0;
      rdValid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      state     <= stateNext;
      row       <= rowNext;
      col       <= colNext;
      colD      <= col;
      vecA      <= vecANext;
      rdValid   <= (state == RUN);
      busy      <= busyNext;
      done      <= doneNext;
      mem_rd    <= memRdNext;
      mem_addr  <= memAddrNext;
      res_valid <= resValidNext;
      res_idx   <= resIdxNext;
      res_data  <= resDataNext;
    end
  end

  always_comb begin
    stateNext = state;
    rowNext   = row;
    colNext   = col;
    vecANext  = vecA;
    accClear  = 1'b0;
    doneNext  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          vecANext  = vec_a;
          rowNext   = '0;
          colNext   = '0;
          accClear  = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (col == LOGN'(N - 1)) begin
          stateNext = DRAIN;
        end else begin
          colNext = col + 1'b1;
        end
      end
      DRAIN: begin
        stateNext = OUT;
      end
      OUT: begin
        if (res_ready) begin
          if (row == LOGN'(N - 1)) begin
            doneNext  = 1'b1;
            stateNext = IDLE;
          end else begin
            rowNext   = row + 1'b1;
            colNext   = '0;
            accClear  = 1'b1;
            stateNext = RUN;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busyNext     = (stateNext != IDLE);
    memRdNext    = (stateNext == RUN);
    memAddrNext  = memRdNext ? AW'({rowNext, colNext}) : '0;
    resValidNext = (stateNext == OUT);
    resIdxNext   = resValidNext ? rowNext : '0;
    resDataNext  = resValidNext ? sat_c : '0;
  end

endmodule
